// File: rtl/frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : frame_deserializer
// Purpose  : Serial-to-parallel frame receiver (start/cmd/addr/data/[parity]/
//            stop) with start/stop/parity checking and a FWFT output FIFO.
// Options  : `FRAME_DESER_PARITY_EN adds an even-parity bit to every frame.
// Revision : 1.0 - initial release
// ============================================================================
module frame_deserializer #(
  parameter int CMD_WIDTH  = 2,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4   // power of two, >= 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sdata_i,
  input  logic                  sclk_i,
  input  logic                  svalid_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [CMD_WIDTH-1:0]  m_cmd_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_parity_err_o,
  output logic                  m_frame_err_o,
  output logic                  abort_o,
  output logic                  overrun_o
);

`ifdef FRAME_DESER_PARITY_EN
  localparam int c_PAR = 1;
`else
  localparam int c_PAR = 0;
`endif
  localparam int c_FW   = CMD_WIDTH + ADDR_WIDTH + DATA_WIDTH + 2 + c_PAR;
  localparam int c_SW   = c_FW - 1;
  localparam int c_CW   = $clog2(c_FW);
  localparam int c_EW   = CMD_WIDTH + ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int c_PW   = $clog2(FIFO_DEPTH);
  localparam int c_CNTW = c_PW + 1;

  // --------------------------------------------------------------------------
  // Input synchronizers and sclk rising-edge strobe
  // --------------------------------------------------------------------------
  logic r_sclk_m, r_sclk_s, r_sclk_d;
  logic r_sdata_m, r_sdata_s;
  logic r_svalid_m, r_svalid_s;
  logic r_sample, r_bit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclk_m   <= 1'b0;
      r_sclk_s   <= 1'b0;
      r_sclk_d   <= 1'b0;
      r_sdata_m  <= 1'b0;
      r_sdata_s  <= 1'b0;
      r_svalid_m <= 1'b0;
      r_svalid_s <= 1'b0;
      r_sample   <= 1'b0;
      r_bit      <= 1'b0;
    end else begin
      r_sclk_m   <= sclk_i;
      r_sclk_s   <= r_sclk_m;
      r_sclk_d   <= r_sclk_s;
      r_sdata_m  <= sdata_i;
      r_sdata_s  <= r_sdata_m;
      r_svalid_m <= svalid_i;
      r_svalid_s <= r_svalid_m;
      // Strobe and captured bit are registered together so they stay aligned.
      r_sample   <= r_sclk_s & ~r_sclk_d;
      r_bit      <= r_sdata_s;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_SW-1:0]   r_shift, w_shift_nxt;
  logic [c_CW-1:0]   r_bitcnt, w_bitcnt_nxt;
  logic              w_abort;
  logic              w_push_req;
  logic              r_abort;
  logic              r_overrun;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_abort  <= w_abort;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_abort      = 1'b0;
    w_push_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Zero bits seen here are idle fill; only a 1 with svalid starts a frame.
        if (r_sample && r_svalid_s && r_bit) begin
          w_state_nxt  = S_SHIFT;
          w_shift_nxt  = '0;
          w_bitcnt_nxt = c_CW'(c_FW - 2);
        end
      end
      S_SHIFT: begin
        if (!r_svalid_s) begin
          w_state_nxt  = S_IDLE;
          w_shift_nxt  = '0;
          w_bitcnt_nxt = '0;
          w_abort      = 1'b1;
        end else if (r_sample) begin
          w_shift_nxt = {r_shift[c_SW-2:0], r_bit};
          if (r_bitcnt == '0) begin
            w_state_nxt = S_CHECK;
          end else begin
            w_bitcnt_nxt = r_bitcnt - c_CW'(1);
          end
        end
      end
      S_CHECK: begin
        w_push_req  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Field split and error checks (shift register = {cmd, addr, data, [par], stop})
  // --------------------------------------------------------------------------
  logic [CMD_WIDTH-1:0]  w_cmd;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_frame_err;
  logic                  w_parity_err;

  assign w_frame_err = r_shift[0];
  assign w_data      = r_shift[c_PAR + 1 +: DATA_WIDTH];
  assign w_addr      = r_shift[c_PAR + 1 + DATA_WIDTH +: ADDR_WIDTH];
  assign w_cmd       = r_shift[c_PAR + 1 + DATA_WIDTH + ADDR_WIDTH +: CMD_WIDTH];

`ifdef FRAME_DESER_PARITY_EN
  assign w_parity_err = (^{w_cmd, w_addr, w_data}) ^ r_shift[1];
`else
  assign w_parity_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output FIFO (first-word fall-through)
  // --------------------------------------------------------------------------
  logic [c_EW-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_CNTW-1:0] r_count;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_overrun;

  assign w_full    = (r_count == c_CNTW'(FIFO_DEPTH));
  assign m_valid_o = (r_count != '0);
  assign w_pop     = m_valid_o && m_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_overrun = w_push_req && !w_push;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_cmd, w_addr, w_data, w_parity_err, w_frame_err};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overrun;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNTW'(1);
        2'b01:   r_count <= r_count - c_CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields read as zero while empty so reset/idle outputs are clean.
  assign {m_cmd_o, m_addr_o, m_data_o, m_parity_err_o, m_frame_err_o} =
      m_valid_o ? r_mem[r_rd_ptr] : '0;

  assign abort_o   = r_abort;
  assign overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_frame_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for frame_deserializer: serial frame driver, queue-based reference
// model of delivered entries, and a negedge monitor that scores every beat.
module tb_frame_deserializer;
  localparam int CW    = 2;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef FRAME_DESER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FW = CW + AW + DW + 2 + P;
  localparam int EW = CW + AW + DW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sdata = 1'b0;
  logic          sclk = 1'b0;
  logic          svalid = 1'b0;
  logic          m_ready = 1'b0;
  logic          m_valid, m_perr, m_ferr, abort, overrun;
  logic [CW-1:0] m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [EW-1:0] head;

  int            n_checks = 0;
  int            n_errors = 0;
  int            beat_cnt = 0;
  int            abort_cnt = 0;
  int            ovr_cnt = 0;
  int            exp_ovr = 0;
  int            ready_mode = 0;  // 0: low, 1: high, 2: toggle every cycle
  logic [EW-1:0] exp_q[$];
  logic          prev_hold = 1'b0;
  logic [EW-1:0] prev_head = '0;

  frame_deserializer #(
    .CMD_WIDTH (CW),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sdata_i       (sdata),
    .sclk_i        (sclk),
    .svalid_i      (svalid),
    .m_valid_o     (m_valid),
    .m_ready_i     (m_ready),
    .m_cmd_o       (m_cmd),
    .m_addr_o      (m_addr),
    .m_data_o      (m_data),
    .m_parity_err_o(m_perr),
    .m_frame_err_o (m_ferr),
    .abort_o       (abort),
    .overrun_o     (overrun)
  );

  assign head = {m_cmd, m_addr, m_data, m_perr, m_ferr};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sole driver of m_ready; changes just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ~m_ready;
      endcase
    end
  end

  // Monitor: scores beats, counts pulses, checks head stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (abort) abort_cnt++;
      if (overrun) ovr_cnt++;
      if (prev_hold && m_valid) check_val("hold_stable", head, prev_head);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check_val("spurious_beat", {63'd0, m_valid}, 64'd0);
        else check_val("beat", head, exp_q.pop_front());
        beat_cnt++;
      end
      prev_hold = m_valid && !m_ready;
      prev_head = head;
    end
  end

  // Drives one frame MSB first; nbits < FW sends a truncated frame and drops svalid.
  task automatic send_frame(input logic [CW-1:0] c, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit bad_par,
                            input bit bad_stop, input int nbits);
    logic [63:0] v;
    logic        par;
    par = (^{c, a, d}) ^ bad_par;
    v = 64'd1;
    v = (v << CW) | 64'(c);
    v = (v << AW) | 64'(a);
    v = (v << DW) | 64'(d);
    if (P == 1) v = (v << 1) | 64'(par);
    v = (v << 1) | 64'(bad_stop);
    @(posedge clk);
    #2;
    svalid = 1'b1;
    for (int i = FW - 1; i >= FW - nbits; i--) begin
      sdata = v[i];
      #20 sclk = 1'b1;
      #20 sclk = 1'b0;
    end
    if (nbits >= FW) begin
      if (exp_q.size() >= DEPTH) exp_ovr++;
      else exp_q.push_back({c, a, d, (P == 1) ? bad_par : 1'b0, bad_stop});
      #40;
      svalid = 1'b0;
      sdata  = 1'b0;
      repeat (2) begin
        #20 sclk = 1'b1;
        #20 sclk = 1'b0;
      end
    end else begin
      svalid = 1'b0;
      sdata  = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check_val(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int b0, a0, o0;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 64'(m_valid), 64'd0);
    check_val("rst_pulses", {62'd0, abort, overrun}, 64'd0);
    check_val("rst_head", 64'(head), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 1;

    // 1: good frame
    b0 = beat_cnt;
    send_frame(2'b01, 14'h1234, 8'hAB, 1'b0, 1'b0, FW);
    wait_drain("t1_drain");
    check_val("t1_beats", 64'(beat_cnt - b0), 64'd1);

    // 2: bad parity, then bad stop bit
    b0 = beat_cnt;
    send_frame(2'b01, 14'h1234, 8'hAB, 1'b1, 1'b0, FW);
    send_frame(2'b10, 14'h0F0F, 8'h5A, 1'b0, 1'b1, FW);
    wait_drain("t2_drain");
    check_val("t2_beats", 64'(beat_cnt - b0), 64'd2);

    // 3: abort after 10 bits, then a clean frame
    b0 = beat_cnt;
    a0 = abort_cnt;
    send_frame(2'b11, 14'h2AAA, 8'hFF, 1'b0, 1'b0, 10);
    repeat (12) @(negedge clk);
    check_val("t3_abort", 64'(abort_cnt - a0), 64'd1);
    check_val("t3_no_beat", 64'(beat_cnt - b0), 64'd0);
    check_val("t3_valid", 64'(m_valid), 64'd0);
    send_frame(CW'($urandom), 14'h0500, 8'h42, 1'b0, 1'b0, FW);
    wait_drain("t3_drain");
    check_val("t3_beats", 64'(beat_cnt - b0), 64'd1);

    // 4: consumer stalled over 5 frames; 5th overruns
    ready_mode = 0;
    o0 = ovr_cnt;
    b0 = beat_cnt;
    for (int i = 1; i <= 5; i++)
      send_frame(CW'($urandom), AW'($urandom), DW'(i), 1'b0, 1'b0, FW);
    repeat (10) @(negedge clk);
    check_val("t4_overrun", 64'(ovr_cnt - o0), 64'd1);
    check_val("t4_valid", 64'(m_valid), 64'd1);
    check_val("t4_head", 64'(m_data), 64'd1);
    ready_mode = 1;
    wait_drain("t4_drain");
    check_val("t4_beats", 64'(beat_cnt - b0), 64'd4);
    check_val("t4_empty", 64'(m_valid), 64'd0);

    // 5: reset mid-frame with entries queued
    ready_mode = 0;
    repeat (2) @(posedge clk);
    send_frame(CW'($urandom), AW'($urandom), 8'h11, 1'b0, 1'b0, FW);
    send_frame(CW'($urandom), AW'($urandom), 8'h22, 1'b0, 1'b0, FW);
    repeat (10) @(negedge clk);
    check_val("t5_queued", 64'(m_valid), 64'd1);
    a0 = abort_cnt;
    send_frame(CW'($urandom), AW'($urandom), 8'h33, 1'b0, 1'b0, 8);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    check_val("t5_valid", 64'(m_valid), 64'd0);
    check_val("t5_head", 64'(head), 64'd0);
    check_val("t5_no_abort", 64'(abort_cnt - a0), 64'd0);
    ready_mode = 1;
    b0 = beat_cnt;
    send_frame(CW'($urandom), AW'($urandom), DW'($urandom), 1'b0, 1'b0, FW);
    wait_drain("t5_drain");
    check_val("t5_beats", 64'(beat_cnt - b0), 64'd1);

    // 6: random stream with ready toggling every cycle
    ready_mode = 2;
    b0 = beat_cnt;
    for (int i = 0; i < 12; i++)
      send_frame(CW'($urandom), AW'($urandom), DW'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), FW);
    ready_mode = 1;
    wait_drain("t6_drain");
    check_val("t6_beats", 64'(beat_cnt - b0), 64'd12);
    check_val("overrun_total", 64'(ovr_cnt), 64'(exp_ovr));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
